mem_access_sequencer: RTL and testbench

- Memory-side handshake partner of the microprogrammed control unit.
- Control unit raises MFA (memory function activate) with a request; this block sequences a byte-wide RAM one byte lane at a time.
- Assembles or splits byte/halfword/word data big-endian, then returns MOC (memory operation complete), the signal the control unit's MOC-check microstates branch on.

---
 rtl/mem_access_sequencer.sv | 91 +++++++++
 tb/tb_mem_access_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences a byte-wide RAM for MFA/MOC requests, big-endian byte/halfword/word.
module mem_access_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              moc,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam logic [2:0] WMAX = 3'(WAIT_CYCLES);
  state_t      state;
  logic [1:0]  idx, nm1, nm1_in, nxt, sh_cur, sh_nxt;
  logic [2:0]  wcnt;
  logic        rw_l;
  logic [31:0] wdata_l;
  // nm1 is both (byte count - 1) and the alignment mask; sh_* select the big-endian lane
  always_comb begin
    nm1_in = size == 2'b00 ? 2'd0 : size == 2'b01 ? 2'd1 : 2'd3;
    nxt    = idx + 2'd1;
    sh_cur = nm1 - idx;
    sh_nxt = nm1 - nxt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      moc       <= 1'b0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      idx       <= '0;
      wcnt      <= '0;
      nm1       <= '0;
      rw_l      <= 1'b0;
      wdata_l   <= '0;
    end else begin
      case (state)
        IDLE: if (mfa) begin
          state     <= XFER;
          busy      <= 1'b1;
          idx       <= '0;
          wcnt      <= '0;
          nm1       <= nm1_in;
          rw_l      <= rw;
          wdata_l   <= wdata;
          ram_en    <= 1'b1;
          ram_we    <= ~rw;
          ram_addr  <= addr & ~ADDR_W'(nm1_in);
          ram_wdata <= wdata[{nm1_in, 3'b000} +: 8];
          if (rw) rdata <= '0;
        end
        XFER: if (wcnt != WMAX) wcnt <= wcnt + 3'd1;
        else begin
          if (rw_l) rdata[{sh_cur, 3'b000} +: 8] <= ram_rdata;
          wcnt <= '0;
          if (idx == nm1) begin
            state  <= DONE;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            moc    <= 1'b1;
          end else begin
            idx       <= nxt;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_l[{sh_nxt, 3'b000} +: 8];
          end
        end
        DONE: if (!mfa) begin
          state <= IDLE;
          moc   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: table-driven transactions against a byte RAM model, scoreboard for rdata.
module tb_mem_access_sequencer;
  logic        clk = 0, reset = 0, mfa = 0, rw = 0;
  logic [1:0]  size = 0;
  logic [8:0]  addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic        moc, busy, ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  mem [0:511];
  logic [31:0] sb [$];
  int total = 0, bad = 0;

  mem_access_sequencer #(.ADDR_W(9), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .mfa(mfa), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .moc(moc), .busy(busy), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_en ? mem[ram_addr] : 8'h00;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic r, input logic [1:0] s, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] e, input int el,
                     input bit drop, input string nm);
    int lat, en;
    logic [31:0] want;
    @(negedge clk);
    rw = r; size = s; addr = a; wdata = d; mfa = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({nm, " accept"}, {30'd0, busy, ram_en}, 32'd3);
    en = ram_en; lat = 0;
    while (!moc && lat < 64) begin
      @(negedge clk);
      rw = ~r; addr = ~a; wdata = ~d; size = ~s;
      if (drop && lat == 1) mfa = 0;
      @(posedge clk); #1;
      lat++; en += int'(ram_en);
    end
    chk({nm, " moc"}, {31'd0, moc}, 32'd1);
    chk({nm, " latency"}, lat, el);
    chk({nm, " en_cycles"}, en, el);
    if (sb.size() == 0) chk({nm, " sb_empty"}, 32'd0, 32'd1);
    else begin
      want = sb.pop_front();
      chk({nm, " rdata"}, rdata, want);
    end
    if (drop) begin
      @(posedge clk); #1;
      chk({nm, " moc_pulse"}, {30'd0, moc, busy}, 32'd0);
      @(posedge clk); #1;
      chk({nm, " idle"}, {30'd0, busy, ram_en}, 32'd0);
    end else begin
      repeat (2) begin
        @(posedge clk); #1;
        chk({nm, " hold"}, {29'd0, moc, busy, ram_en}, 32'd6);
      end
      @(negedge clk); mfa = 0;
      @(posedge clk); #1;
      chk({nm, " release"}, {30'd0, moc, busy}, 32'd0);
    end
  endtask

  typedef struct {
    logic r; logic [1:0] s; logic [8:0] a; logic [31:0] d; logic [31:0] e; int l;
  } vec_t;
  vec_t v [13];

  initial begin
    v[0]  = '{1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 32'h00000000, 8};
    v[1]  = '{1'b1, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 8};
    v[2]  = '{1'b1, 2'b00, 9'h013, 32'h0,        32'h000000EF, 2};
    v[3]  = '{1'b1, 2'b01, 9'h011, 32'h0,        32'h0000DEAD, 4};
    v[4]  = '{1'b1, 2'b01, 9'h012, 32'h0,        32'h0000BEEF, 4};
    v[5]  = '{1'b0, 2'b10, 9'h013, 32'h01234567, 32'h0000BEEF, 8};
    v[6]  = '{1'b1, 2'b10, 9'h010, 32'h0,        32'h01234567, 8};
    v[7]  = '{1'b0, 2'b00, 9'h101, 32'hFFFFFFA5, 32'h01234567, 2};
    v[8]  = '{1'b0, 2'b01, 9'h102, 32'hAAAA1234, 32'h01234567, 4};
    v[9]  = '{1'b1, 2'b11, 9'h100, 32'h0,        32'h00A51234, 8};
    v[10] = '{1'b0, 2'b00, 9'h1FF, 32'h0000005A, 32'h00A51234, 2};
    v[11] = '{1'b1, 2'b11, 9'h1FE, 32'h0,        32'h0000005A, 8};
    v[12] = '{1'b1, 2'b00, 9'h010, 32'h0,        32'h00000001, 2};
    for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    reset = 0; mfa = 1; rw = 1; size = 2'b10; addr = 9'h010;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset outs", {28'd0, moc, busy, ram_en, ram_we}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
    end
    @(negedge clk); reset = 1; mfa = 0;
    @(posedge clk); #1;
    chk("post reset idle", {30'd0, busy, ram_en}, 32'd0);
    for (int i = 0; i < 13; i++)
      txn(v[i].r, v[i].s, v[i].a, v[i].d, v[i].e, v[i].l, 1'b0, $sformatf("vec%0d", i));
    chk("ram 0x10", {24'd0, mem[9'h010]}, 32'h01);
    chk("ram 0x13", {24'd0, mem[9'h013]}, 32'h67);
    txn(1'b1, 2'b10, 9'h010, 32'h0, 32'h01234567, 8, 1'b1, "drop");
    @(negedge clk);
    rw = 0; size = 2'b10; addr = 9'h010; wdata = 32'hCAFEF00D; mfa = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("midrst outs", {28'd0, moc, busy, ram_en, ram_we}, 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    chk("midrst addr", {23'd0, ram_addr}, 32'd0);
    chk("midrst ram10", {24'd0, mem[9'h010]}, 32'hCA);
    chk("midrst ram11", {24'd0, mem[9'h011]}, 32'h23);
    chk("midrst ram12", {24'd0, mem[9'h012]}, 32'h45);
    chk("midrst ram13", {24'd0, mem[9'h013]}, 32'h67);
    @(negedge clk); reset = 1; mfa = 0;
    txn(1'b1, 2'b10, 9'h010, 32'h0, 32'hCA234567, 8, 1'b0, "after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
